// File: rtl/traffic_led_monitor.sv
// Passive checker for a two-road traffic controller: decodes the lamp drives
// into phases, tracks their order and durations, and latches sticky errors.
module traffic_led_monitor #(
    parameter int G1_LEN = 30,
    parameter int Y_LEN  = 5,
    parameter int G2_LEN = 25,
    parameter int TOL    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r1,
    input  logic       g1,
    input  logic       y1,
    input  logic       r2,
    input  logic       g2,
    input  logic       y2,
    input  logic       clr,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       err_conflict,
    output logic       err_seq,
    output logic       err_time,
    output logic [1:0] first_err,
    output logic [7:0] cycle_cnt,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] lamp_q;
    logic       lamp_vld_q;
    logic [7:0] dur_q, dur_d;
    logic       unchk_q, unchk_d;
    logic [1:0] phase_q, phase_d;
    logic       valid_q, valid_d;
    logic       err_c_q, err_c_d;
    logic       err_s_q, err_s_d;
    logic       err_t_q, err_t_d;
    logic [1:0] first_q, first_d;
    logic [7:0] cnt_q, cnt_d;

    logic       legal;
    logic [1:0] dec;
    logic       new_c, new_s, new_t;
    logic [1:0] first_base;

    function automatic logic [7:0] len_min(input logic [1:0] ph);
        case (ph)
            2'd0:    return 8'(G1_LEN - TOL);
            2'd2:    return 8'(G2_LEN - TOL);
            default: return 8'(Y_LEN - TOL);
        endcase
    endfunction

    function automatic logic [7:0] len_over(input logic [1:0] ph);
        case (ph)
            2'd0:    return 8'(G1_LEN + TOL + 1);
            2'd2:    return 8'(G2_LEN + TOL + 1);
            default: return 8'(Y_LEN + TOL + 1);
        endcase
    endfunction

    always_comb begin
        legal = 1'b1;
        dec   = 2'd0;
        case (lamp_q)
            6'b010100: dec = 2'd0;
            6'b001100: dec = 2'd1;
            6'b100010: dec = 2'd2;
            6'b100001: dec = 2'd3;
            default:   legal = 1'b0;
        endcase
    end

    // lamp_vld_q masks the all-zero lamp_q left behind by reset so it is not
    // mistaken for an all-lamps-off conflict.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        valid_d = valid_q;
        dur_d   = dur_q;
        unchk_d = unchk_q;
        cnt_d   = cnt_q;
        new_c   = 1'b0;
        new_s   = 1'b0;
        new_t   = 1'b0;
        if (lamp_vld_q) begin
            if (!legal) begin
                new_c   = 1'b1;
                state_d = HOLD;
                valid_d = 1'b0;
            end else if (state_q != RUN) begin
                state_d = RUN;
                valid_d = 1'b1;
                phase_d = dec;
                dur_d   = 8'd1;
                unchk_d = 1'b1;
            end else if (dec != phase_q) begin
                if (dec != 2'(phase_q + 2'd1)) new_s = 1'b1;
                // Overlong phases were already flagged while they held.
                if (!unchk_q && dur_q < len_min(phase_q)) new_t = 1'b1;
                if (phase_q == 2'd3 && dec == 2'd0) cnt_d = cnt_q + 8'd1;
                phase_d = dec;
                dur_d   = 8'd1;
                unchk_d = 1'b0;
            end else if (dur_q != 8'hff) begin
                dur_d = dur_q + 8'd1;
                if (!unchk_q && dur_d == len_over(phase_q)) new_t = 1'b1;
            end
        end

        err_c_d    = (clr ? 1'b0 : err_c_q) | new_c;
        err_s_d    = (clr ? 1'b0 : err_s_q) | new_s;
        err_t_d    = (clr ? 1'b0 : err_t_q) | new_t;
        first_base = clr ? 2'd0 : first_q;
        first_d    = first_base;
        if (first_base == 2'd0) begin
            if (new_c)      first_d = 2'd1;
            else if (new_s) first_d = 2'd2;
            else if (new_t) first_d = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamp_q     <= 6'd0;
            lamp_vld_q <= 1'b0;
            state_q    <= SYNC;
            dur_q      <= 8'd0;
            unchk_q    <= 1'b0;
            phase_q    <= 2'd0;
            valid_q    <= 1'b0;
            err_c_q    <= 1'b0;
            err_s_q    <= 1'b0;
            err_t_q    <= 1'b0;
            first_q    <= 2'd0;
            cnt_q      <= 8'd0;
        end else begin
            lamp_q     <= {r1, g1, y1, r2, g2, y2};
            lamp_vld_q <= 1'b1;
            state_q    <= state_d;
            dur_q      <= dur_d;
            unchk_q    <= unchk_d;
            phase_q    <= phase_d;
            valid_q    <= valid_d;
            err_c_q    <= err_c_d;
            err_s_q    <= err_s_d;
            err_t_q    <= err_t_d;
            first_q    <= first_d;
            cnt_q      <= cnt_d;
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = valid_q;
    assign err_conflict = err_c_q;
    assign err_seq      = err_s_q;
    assign err_time     = err_t_q;
    assign first_err    = first_q;
    assign cycle_cnt    = cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_traffic_led_monitor.sv
// Scenario bench for traffic_led_monitor: expected output words are queued
// as each stimulus step is driven and popped when the outputs are sampled.
module tb_traffic_led_monitor;

    localparam logic [5:0] L_S0  = 6'b010100;
    localparam logic [5:0] L_S1  = 6'b001100;
    localparam logic [5:0] L_S2  = 6'b100010;
    localparam logic [5:0] L_S3  = 6'b100001;
    localparam logic [5:0] L_BAD = 6'b010010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r1, g1, y1, r2, g2, y2;
    logic       clr;
    logic [1:0] phase;
    logic       phase_valid;
    logic       err_conflict, err_seq, err_time;
    logic [1:0] first_err;
    logic [7:0] cycle_cnt;
    logic [1:0] state_dbg;

    logic [15:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    traffic_led_monitor dut (
        .clk(clk), .rst_n(rst_n),
        .r1(r1), .g1(g1), .y1(y1), .r2(r2), .g2(g2), .y2(y2),
        .clr(clr),
        .phase(phase), .phase_valid(phase_valid),
        .err_conflict(err_conflict), .err_seq(err_seq), .err_time(err_time),
        .first_err(first_err), .cycle_cnt(cycle_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Output word: {phase, phase_valid, conflict, seq, time, first_err, cycle_cnt}
    function automatic logic [15:0] mk(input logic [1:0] ph, input logic v,
                                       input logic c, input logic s, input logic t,
                                       input logic [1:0] fe, input logic [7:0] cnt);
        return {ph, v, c, s, t, fe, cnt};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] l, input int n);
        {r1, g1, y1, r2, g2, y2} = l;
        repeat (n) tick();
    endtask

    task automatic push_exp(input logic [15:0] e);
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, {phase, phase_valid, err_conflict, err_seq, err_time,
                            first_err, cycle_cnt}, e);
        end
    endtask

    task automatic pulse_clr(input logic [5:0] l);
        clr = 1'b1;
        run(l, 1);
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        {r1, g1, y1, r2, g2, y2} = L_S0;
        repeat (2) tick();
        push_exp(mk(2'd0, 0, 0, 0, 0, 2'd0, 8'd0));
        pop_check("reset_state");

        rst_n = 1'b1;
        push_exp(mk(2'd0, 0, 0, 0, 0, 2'd0, 8'd0));
        run(L_S0, 1);
        pop_check("lock_plus1");
        push_exp(mk(2'd0, 1, 0, 0, 0, 2'd0, 8'd0));
        run(L_S0, 1);
        pop_check("lock_plus2");
        run(L_S0, 10);

        // Three legal rounds 30/5/25/5
        for (int r = 1; r <= 3; r++) begin
            push_exp(mk(2'd1, 1, 0, 0, 0, 2'd0, 8'(r - 1)));
            run(L_S1, 2);
            pop_check("round_s1");
            run(L_S1, 3);
            push_exp(mk(2'd2, 1, 0, 0, 0, 2'd0, 8'(r - 1)));
            run(L_S2, 2);
            pop_check("round_s2");
            run(L_S2, 23);
            push_exp(mk(2'd3, 1, 0, 0, 0, 2'd0, 8'(r - 1)));
            run(L_S3, 2);
            pop_check("round_s3");
            run(L_S3, 3);
            push_exp(mk(2'd0, 1, 0, 0, 0, 2'd0, 8'(r)));
            run(L_S0, 2);
            pop_check("round_s0_cnt");
            run(L_S0, 28);
        end

        // Overlong S0: duration 31 still fine, 32 flags time
        push_exp(mk(2'd0, 1, 0, 0, 0, 2'd0, 8'd3));
        run(L_S0, 2);
        pop_check("s0_dur31");
        push_exp(mk(2'd0, 1, 0, 0, 1, 2'd3, 8'd3));
        run(L_S0, 1);
        pop_check("s0_dur32_time");
        push_exp(mk(2'd0, 1, 0, 0, 0, 2'd0, 8'd3));
        pulse_clr(L_S0);
        pop_check("clr_after_time");

        // S0 -> S2 skips S1
        push_exp(mk(2'd2, 1, 0, 1, 0, 2'd2, 8'd3));
        run(L_S2, 2);
        pop_check("seq_skip");
        run(L_S2, 23);
        run(L_S3, 5);
        push_exp(mk(2'd0, 1, 0, 1, 0, 2'd2, 8'd4));
        run(L_S0, 2);
        pop_check("seq_sticky_cnt4");
        pulse_clr(L_S0);

        // Both greens for one cycle mid-S0
        run(L_S0, 7);
        run(L_BAD, 1);
        push_exp(mk(2'd0, 0, 1, 0, 0, 2'd1, 8'd4));
        run(L_S0, 1);
        pop_check("conflict_hold");
        push_exp(mk(2'd0, 1, 1, 0, 0, 2'd1, 8'd4));
        run(L_S0, 1);
        pop_check("conflict_relock");
        run(L_S0, 18);
        run(L_S1, 5);
        push_exp(mk(2'd2, 1, 1, 0, 0, 2'd1, 8'd4));
        run(L_S2, 2);
        pop_check("relock_no_time");

        // Short S1 ending in the same cycle as clr
        push_exp(mk(2'd2, 1, 0, 0, 0, 2'd0, 8'd4));
        pulse_clr(L_S2);
        pop_check("clr_conflict");
        run(L_S2, 22);
        run(L_S3, 5);
        run(L_S0, 30);
        run(L_S1, 3);
        run(L_S2, 1);
        push_exp(mk(2'd2, 1, 0, 0, 1, 2'd3, 8'd5));
        pulse_clr(L_S2);
        pop_check("clr_same_cycle_time");
        run(L_S2, 3);
        push_exp(mk(2'd2, 1, 0, 0, 0, 2'd0, 8'd5));
        pulse_clr(L_S2);
        pop_check("clr_no_error");

        // Asynchronous reset mid-S2
        run(L_S2, 3);
        rst_n = 1'b0;
        #1;
        push_exp(mk(2'd0, 0, 0, 0, 0, 2'd0, 8'd0));
        pop_check("async_reset");
        tick();
        rst_n = 1'b1;
        push_exp(mk(2'd0, 0, 0, 0, 0, 2'd0, 8'd0));
        run(L_S2, 1);
        pop_check("post_reset_plus1");
        push_exp(mk(2'd2, 1, 0, 0, 0, 2'd0, 8'd0));
        run(L_S2, 1);
        pop_check("post_reset_lock");
        run(L_S2, 20);
        run(L_S3, 5);
        push_exp(mk(2'd0, 1, 0, 0, 0, 2'd0, 8'd1));
        run(L_S0, 2);
        pop_check("post_reset_cnt1");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
